// File: rtl/isp_cfg_pkg.sv
// Shared definitions for the ISP configuration controller: register map,
// tracker FSM encoding, reset defaults and the shadow/active register payload.
package isp_cfg_pkg;

  localparam int unsigned CFG_ADDR_W  = 3;
  localparam int unsigned CFG_DATA_W  = 8;
  localparam int unsigned MODE_W      = 3;
  localparam int unsigned GAMMA_W     = 3;
  localparam int unsigned GAIN_W      = 8;
  localparam int unsigned BAYER_W     = 4;
  localparam int unsigned FRAME_CNT_W = 16;

  localparam logic [CFG_ADDR_W-1:0] ADDR_MODE   = 3'd0;
  localparam logic [CFG_ADDR_W-1:0] ADDR_GAMMA  = 3'd1;
  localparam logic [CFG_ADDR_W-1:0] ADDR_R_GAIN = 3'd2;
  localparam logic [CFG_ADDR_W-1:0] ADDR_G_GAIN = 3'd3;
  localparam logic [CFG_ADDR_W-1:0] ADDR_B_GAIN = 3'd4;
  localparam logic [CFG_ADDR_W-1:0] ADDR_BAYER  = 3'd5;
  localparam logic [CFG_ADDR_W-1:0] ADDR_COMMIT = 3'd6;
  localparam logic [CFG_ADDR_W-1:0] ADDR_RSVD   = 3'd7;

  localparam logic [GAIN_W-1:0]  GAIN_RST_DEF  = 8'h40;
  localparam logic [MODE_W-1:0]  MODE_RST_DEF  = 3'b100;
  localparam logic [BAYER_W-1:0] BAYER_RST_DEF = 4'b0001;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } trk_state_e;

  typedef struct packed {
    logic [MODE_W-1:0]  mode;
    logic [GAMMA_W-1:0] gamma;
    logic [GAIN_W-1:0]  r_gain;
    logic [GAIN_W-1:0]  g_gain;
    logic [GAIN_W-1:0]  b_gain;
    logic [BAYER_W-1:0] bayer;
  } cfg_regs_t;

  // Apply one host write to a register set; commit/reserved leave it untouched.
  function automatic cfg_regs_t cfg_write(input cfg_regs_t cur,
                                          input logic [CFG_ADDR_W-1:0] addr,
                                          input logic [CFG_DATA_W-1:0] wdata);
    cfg_regs_t nxt;
    nxt = cur;
    case (addr)
      ADDR_MODE:   nxt.mode   = wdata[MODE_W-1:0];
      ADDR_GAMMA:  nxt.gamma  = wdata[GAMMA_W-1:0];
      ADDR_R_GAIN: nxt.r_gain = wdata;
      ADDR_G_GAIN: nxt.g_gain = wdata;
      ADDR_B_GAIN: nxt.b_gain = wdata;
      ADDR_BAYER:  nxt.bayer  = wdata[BAYER_W-1:0];
      default:     nxt = cur;
    endcase
    return nxt;
  endfunction

  function automatic logic [CFG_DATA_W-1:0] cfg_read(input cfg_regs_t regs,
                                                     input logic [CFG_ADDR_W-1:0] addr);
    logic [CFG_DATA_W-1:0] data;
    data = '0;
    case (addr)
      ADDR_MODE:   data = CFG_DATA_W'(regs.mode);
      ADDR_GAMMA:  data = CFG_DATA_W'(regs.gamma);
      ADDR_R_GAIN: data = regs.r_gain;
      ADDR_G_GAIN: data = regs.g_gain;
      ADDR_B_GAIN: data = regs.b_gain;
      ADDR_BAYER:  data = CFG_DATA_W'(regs.bayer);
      default:     data = '0;
    endcase
    return data;
  endfunction

endpackage

// File: rtl/isp_frame_tracker.sv
// Frame position tracker: latches geometry at frame start, counts pixels and
// lines on data_en, and produces registered frame_start/frame_end/frame_cnt.
module isp_frame_tracker
  import isp_cfg_pkg::*;
#(
  parameter int unsigned GEOM_W = 12
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   data_en_i,
  input  logic [GEOM_W-1:0]      h_active_i,
  input  logic [GEOM_W-1:0]      v_active_i,
  output trk_state_e             state_o,
  output logic                   frame_start_o,
  output logic                   frame_end_o,
  output logic [FRAME_CNT_W-1:0] frame_cnt_o
);

  trk_state_e             state_q, state_d;
  logic [GEOM_W-1:0]      h_geom_q, h_geom_d, v_geom_q, v_geom_d;
  logic [GEOM_W-1:0]      pix_q, pix_d, line_q, line_d;
  logic                   fs_q, fs_d, fe_q, fe_d;
  logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;

  logic [GEOM_W-1:0] cur_h, cur_v, cur_pix, cur_line;
  logic              eol, eof;

  // In IDLE the incoming pixel is pixel 0 of a frame using the live geometry;
  // a zero geometry wraps its last-index compare to all-ones (2^GEOM_W).
  always_comb begin
    state_d  = state_q;
    h_geom_d = h_geom_q;
    v_geom_d = v_geom_q;
    pix_d    = pix_q;
    line_d   = line_q;
    fs_d     = 1'b0;
    fe_d     = 1'b0;
    cnt_d    = cnt_q;

    cur_h    = (state_q == ST_IDLE) ? h_active_i : h_geom_q;
    cur_v    = (state_q == ST_IDLE) ? v_active_i : v_geom_q;
    cur_pix  = (state_q == ST_IDLE) ? '0 : pix_q;
    cur_line = (state_q == ST_IDLE) ? '0 : line_q;
    eol      = (cur_pix == cur_h - GEOM_W'(1));
    eof      = eol && (cur_line == cur_v - GEOM_W'(1));

    if (data_en_i) begin
      if (state_q == ST_IDLE) begin
        h_geom_d = h_active_i;
        v_geom_d = v_active_i;
        fs_d     = 1'b1;
      end
      if (eof) begin
        fe_d    = 1'b1;
        cnt_d   = cnt_q + FRAME_CNT_W'(1);
        state_d = ST_IDLE;
        pix_d   = '0;
        line_d  = '0;
      end else begin
        state_d = ST_ACTIVE;
        pix_d   = eol ? '0 : cur_pix + GEOM_W'(1);
        line_d  = eol ? cur_line + GEOM_W'(1) : cur_line;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      h_geom_q <= '0;
      v_geom_q <= '0;
      pix_q    <= '0;
      line_q   <= '0;
      fs_q     <= 1'b0;
      fe_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      h_geom_q <= h_geom_d;
      v_geom_q <= v_geom_d;
      pix_q    <= pix_d;
      line_q   <= line_d;
      fs_q     <= fs_d;
      fe_q     <= fe_d;
      cnt_q    <= cnt_d;
    end
  end

  assign state_o       = state_q;
  assign frame_start_o = fs_q;
  assign frame_end_o   = fe_q;
  assign frame_cnt_o   = cnt_q;

endmodule

// File: rtl/isp_cfg_ctrl.sv
// Frame-synchronous ISP configuration controller: host shadow registers with an
// armed commit applied atomically between frames. Optional readback port is
// enabled by defining ISP_CFG_READBACK_EN.
module isp_cfg_ctrl
  import isp_cfg_pkg::*;
#(
  parameter int unsigned        GEOM_W    = 12,
  parameter logic [GAIN_W-1:0]  GAIN_RST  = GAIN_RST_DEF,
  parameter logic [MODE_W-1:0]  MODE_RST  = MODE_RST_DEF,
  parameter logic [BAYER_W-1:0] BAYER_RST = BAYER_RST_DEF
) (
  input  logic                   isp_clk,
  input  logic                   rst_n,
  input  logic                   data_en,
  input  logic [GEOM_W-1:0]      h_active_in,
  input  logic [GEOM_W-1:0]      v_active_in,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [CFG_ADDR_W-1:0]  cfg_addr,
  input  logic [CFG_DATA_W-1:0]  cfg_wdata,
  output logic [MODE_W-1:0]      mode_sel,
  output logic [GAMMA_W-1:0]     gamma_coe,
  output logic [GAIN_W-1:0]      r_gain,
  output logic [GAIN_W-1:0]      g_gain,
  output logic [GAIN_W-1:0]      b_gain,
  output logic [BAYER_W-1:0]     bayer_start,
  output logic                   cfg_pending,
  output logic                   frame_start,
  output logic                   frame_end,
  output logic [FRAME_CNT_W-1:0] frame_cnt
`ifdef ISP_CFG_READBACK_EN
  ,
  input  logic [CFG_ADDR_W-1:0]  rd_addr,
  input  logic                   rd_sel,
  output logic [CFG_DATA_W-1:0]  rd_data
`endif
);

  localparam cfg_regs_t CFG_RST = '{
    mode:   MODE_RST,
    gamma:  '0,
    r_gain: GAIN_RST,
    g_gain: GAIN_RST,
    b_gain: GAIN_RST,
    bayer:  BAYER_RST
  };

  cfg_regs_t  shadow_q, shadow_d, active_q, active_d;
  logic       pending_q, pending_d, ready_q;
  logic       wr_fire;
  trk_state_e trk_state;

  isp_frame_tracker #(
    .GEOM_W (GEOM_W)
  ) u_tracker (
    .clk_i         (isp_clk),
    .rst_ni        (rst_n),
    .data_en_i     (data_en),
    .h_active_i    (h_active_in),
    .v_active_i    (v_active_in),
    .state_o       (trk_state),
    .frame_start_o (frame_start),
    .frame_end_o   (frame_end),
    .frame_cnt_o   (frame_cnt)
  );

  // An armed commit lands whenever the tracker sits between frames; while
  // armed, ready is low so no write can race the apply.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    wr_fire   = cfg_valid && ready_q;

    if (pending_q && (trk_state == ST_IDLE)) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end else if (wr_fire) begin
      if (cfg_addr == ADDR_COMMIT) begin
        pending_d = 1'b1;
      end else begin
        shadow_d = cfg_write(shadow_q, cfg_addr, cfg_wdata);
      end
    end
  end

  always_ff @(posedge isp_clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q  <= CFG_RST;
      active_q  <= CFG_RST;
      pending_q <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      ready_q   <= !pending_d;
    end
  end

  assign cfg_ready   = ready_q;
  assign cfg_pending = pending_q;
  assign mode_sel    = active_q.mode;
  assign gamma_coe   = active_q.gamma;
  assign r_gain      = active_q.r_gain;
  assign g_gain      = active_q.g_gain;
  assign b_gain      = active_q.b_gain;
  assign bayer_start = active_q.bayer;

`ifdef ISP_CFG_READBACK_EN
  logic [CFG_DATA_W-1:0] rd_data_q;

  always_ff @(posedge isp_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (rd_addr == ADDR_COMMIT) begin
      rd_data_q <= CFG_DATA_W'(pending_q);
    end else if (rd_addr == ADDR_RSVD) begin
      rd_data_q <= frame_cnt[CFG_DATA_W-1:0];
    end else begin
      rd_data_q <= cfg_read(rd_sel ? shadow_q : active_q, rd_addr);
    end
  end

  assign rd_data = rd_data_q;
`endif

endmodule

// File: tb/tb_isp_cfg_ctrl.sv
// Directed self-checking bench for isp_cfg_ctrl (default build, no readback).
module tb_isp_cfg_ctrl;
  import isp_cfg_pkg::*;

  localparam int unsigned GEOM_W = 12;

  logic              isp_clk = 1'b0;
  logic              rst_n;
  logic              data_en;
  logic [GEOM_W-1:0] h_active_in, v_active_in;
  logic              cfg_valid, cfg_ready;
  logic [2:0]        cfg_addr;
  logic [7:0]        cfg_wdata;
  logic [2:0]        mode_sel, gamma_coe;
  logic [7:0]        r_gain, g_gain, b_gain;
  logic [3:0]        bayer_start;
  logic              cfg_pending, frame_start, frame_end;
  logic [15:0]       frame_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 isp_clk = ~isp_clk;

  isp_cfg_ctrl #(.GEOM_W(GEOM_W)) dut (
    .isp_clk     (isp_clk),
    .rst_n       (rst_n),
    .data_en     (data_en),
    .h_active_in (h_active_in),
    .v_active_in (v_active_in),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .mode_sel    (mode_sel),
    .gamma_coe   (gamma_coe),
    .r_gain      (r_gain),
    .g_gain      (g_gain),
    .b_gain      (b_gain),
    .bayer_start (bayer_start),
    .cfg_pending (cfg_pending),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .frame_cnt   (frame_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, sample 1 time unit later.
  task automatic cyc(input logic de, input logic v, input logic [2:0] a, input logic [7:0] d);
    data_en   = de;
    cfg_valid = v;
    cfg_addr  = a;
    cfg_wdata = d;
    @(posedge isp_clk);
    #1;
    data_en   = 1'b0;
    cfg_valid = 1'b0;
  endtask

  task automatic run_to_fe(input int max_pix, output int n);
    n = -1;
    for (int i = 1; i <= max_pix; i++) begin
      cyc(1'b1, 1'b0, 3'd0, 8'h00);
      if (frame_end) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic chk_defaults(input string tag);
    chk({tag, "_mode"},  32'(mode_sel),    32'h4);
    chk({tag, "_gamma"}, 32'(gamma_coe),   32'h0);
    chk({tag, "_r"},     32'(r_gain),      32'h40);
    chk({tag, "_g"},     32'(g_gain),      32'h40);
    chk({tag, "_b"},     32'(b_gain),      32'h40);
    chk({tag, "_bayer"}, 32'(bayer_start), 32'h1);
    chk({tag, "_ready"}, 32'(cfg_ready),   32'h1);
    chk({tag, "_pend"},  32'(cfg_pending), 32'h0);
  endtask

  initial begin
    int   n;
    int   cnt;
    logic any;
    logic de;

    rst_n = 1'b0; data_en = 1'b0; cfg_valid = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    h_active_in = 12'd4; v_active_in = 12'd2;
    repeat (3) @(posedge isp_clk);
    #1;
    chk_defaults("rst");
    chk("rst_fs", 32'(frame_start), 32'h0);
    chk("rst_fe", 32'(frame_end),   32'h0);
    chk("rst_fc", 32'(frame_cnt),   32'h0);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 3'd0, 8'h00);
    cyc(1'b0, 1'b0, 3'd0, 8'h00);
    chk_defaults("idle");

    // 4x2 frame, continuous data_en
    cyc(1'b1, 1'b0, 3'd0, 8'h00);
    chk("f1_fs1", 32'(frame_start), 32'h1);
    chk("f1_fe1", 32'(frame_end),   32'h0);
    any = 1'b0;
    for (int i = 2; i <= 7; i++) begin
      cyc(1'b1, 1'b0, 3'd0, 8'h00);
      any = any | frame_start | frame_end;
    end
    chk("f1_mid_pulses", 32'(any), 32'h0);
    cyc(1'b1, 1'b0, 3'd0, 8'h00);
    chk("f1_fe8",  32'(frame_end),   32'h1);
    chk("f1_fs8",  32'(frame_start), 32'h0);
    chk("f1_fc",   32'(frame_cnt),   32'h1);
    chk("f1_idle", 32'(dut.u_tracker.state_q), 32'(ST_IDLE));
    cyc(1'b0, 1'b0, 3'd0, 8'h00);
    chk("f1_fe_drop", 32'(frame_end), 32'h0);

    // Mid-frame write + commit, held until frame end
    cyc(1'b1, 1'b0, 3'd0, 8'h00);
    cyc(1'b1, 1'b0, 3'd0, 8'h00);
    cyc(1'b1, 1'b1, ADDR_R_GAIN, 8'h80);
    cyc(1'b1, 1'b1, ADDR_COMMIT, 8'h00);
    chk("mc_r_hold", 32'(r_gain),      32'h40);
    chk("mc_pend",   32'(cfg_pending), 32'h1);
    chk("mc_ready",  32'(cfg_ready),   32'h0);
    cyc(1'b1, 1'b1, ADDR_R_GAIN, 8'hAA);
    cyc(1'b1, 1'b0, 3'd0, 8'h00);
    cyc(1'b1, 1'b0, 3'd0, 8'h00);
    cyc(1'b1, 1'b0, 3'd0, 8'h00);
    chk("mc_fe",       32'(frame_end), 32'h1);
    chk("mc_r_at_fe",  32'(r_gain),    32'h40);
    chk("mc_rdy_at_fe", 32'(cfg_ready), 32'h0);
    cyc(1'b0, 1'b0, 3'd0, 8'h00);
    chk("mc_r_new",  32'(r_gain),      32'h80);
    chk("mc_pend0",  32'(cfg_pending), 32'h0);
    chk("mc_ready1", 32'(cfg_ready),   32'h1);
    chk("mc_fc",     32'(frame_cnt),   32'h2);

    // Commit on the frame_end cycle
    cyc(1'b0, 1'b1, ADDR_G_GAIN, 8'h20);
    for (int i = 1; i <= 7; i++) cyc(1'b1, 1'b0, 3'd0, 8'h00);
    cyc(1'b1, 1'b1, ADDR_COMMIT, 8'h00);
    chk("ce_fe",   32'(frame_end),   32'h1);
    chk("ce_pend", 32'(cfg_pending), 32'h1);
    chk("ce_g_old", 32'(g_gain),     32'h40);
    cyc(1'b0, 1'b0, 3'd0, 8'h00);
    chk("ce_g_new", 32'(g_gain),      32'h20);
    chk("ce_r_kept", 32'(r_gain),     32'h80);
    chk("ce_pend0", 32'(cfg_pending), 32'h0);
    chk("ce_fc",    32'(frame_cnt),   32'h3);

    // Commit on the frame_start cycle: deferred to that frame's end
    cyc(1'b0, 1'b1, ADDR_B_GAIN, 8'h10);
    cyc(1'b1, 1'b1, ADDR_COMMIT, 8'h00);
    chk("cs_fs",   32'(frame_start), 32'h1);
    chk("cs_pend", 32'(cfg_pending), 32'h1);
    for (int i = 2; i <= 7; i++) cyc(1'b1, 1'b0, 3'd0, 8'h00);
    chk("cs_b_mid", 32'(b_gain), 32'h40);
    cyc(1'b1, 1'b0, 3'd0, 8'h00);
    chk("cs_fe",    32'(frame_end), 32'h1);
    chk("cs_b_fe",  32'(b_gain),    32'h40);
    cyc(1'b0, 1'b0, 3'd0, 8'h00);
    chk("cs_b_new", 32'(b_gain),    32'h10);
    chk("cs_fc",    32'(frame_cnt), 32'h4);

    // Geometry change mid-frame is ignored until next frame start
    cyc(1'b1, 1'b0, 3'd0, 8'h00);
    cyc(1'b1, 1'b0, 3'd0, 8'h00);
    h_active_in = 12'd6;
    run_to_fe(20, n);
    chk("gc_old_len", 32'(n + 2), 32'd8);
    cyc(1'b0, 1'b0, 3'd0, 8'h00);
    run_to_fe(30, n);
    chk("gc_new_len", 32'(n), 32'd12);
    chk("gc_fc", 32'(frame_cnt), 32'h6);

    // Blanking gaps hold the counters
    h_active_in = 12'd4;
    cyc(1'b0, 1'b0, 3'd0, 8'h00);
    cnt = 0; de = 1'b0; n = -1;
    for (int i = 0; i < 60; i++) begin
      de = ((i % 3) != 2);
      cyc(de, 1'b0, 3'd0, 8'h00);
      if (de) cnt++;
      if (frame_end) begin
        n = cnt;
        break;
      end
    end
    chk("gap_len",   32'(n),  32'd8);
    chk("gap_de_fe", 32'(de), 32'h1);
    chk("gap_fc", 32'(frame_cnt), 32'h7);

    // Single-pixel frame
    h_active_in = 12'd1; v_active_in = 12'd1;
    cyc(1'b0, 1'b0, 3'd0, 8'h00);
    cyc(1'b1, 1'b0, 3'd0, 8'h00);
    chk("sp_fs",   32'(frame_start), 32'h1);
    chk("sp_fe",   32'(frame_end),   32'h1);
    chk("sp_idle", 32'(dut.u_tracker.state_q), 32'(ST_IDLE));
    chk("sp_fc",   32'(frame_cnt),   32'h8);

    // Zero width means 2^GEOM_W pixels per line
    h_active_in = 12'd0;
    cyc(1'b0, 1'b0, 3'd0, 8'h00);
    run_to_fe(5000, n);
    chk("zw_len", 32'(n), 32'd4096);
    chk("zw_fc",  32'(frame_cnt), 32'h9);

    // Async reset mid-frame with a commit armed
    h_active_in = 12'd4; v_active_in = 12'd2;
    cyc(1'b0, 1'b0, 3'd0, 8'h00);
    cyc(1'b1, 1'b0, 3'd0, 8'h00);
    cyc(1'b1, 1'b0, 3'd0, 8'h00);
    cyc(1'b1, 1'b1, ADDR_MODE, 8'h01);
    cyc(1'b1, 1'b1, ADDR_COMMIT, 8'h00);
    chk("ar_pend_before", 32'(cfg_pending), 32'h1);
    rst_n = 1'b0;
    #1;
    chk_defaults("ar");
    chk("ar_fc",   32'(frame_cnt), 32'h0);
    chk("ar_idle", 32'(dut.u_tracker.state_q), 32'(ST_IDLE));
    @(posedge isp_clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 3'd0, 8'h00);
    run_to_fe(20, n);
    chk("ar_len", 32'(n), 32'd8);
    cyc(1'b0, 1'b0, 3'd0, 8'h00);
    chk("ar_mode_kept", 32'(mode_sel),  32'h4);
    chk("ar_fc1",       32'(frame_cnt), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/isp_cfg_ctrl.md
Name: isp_cfg_ctrl

Overview:
- Frame-synchronous configuration controller for the ISP pipeline.
- Host writes runtime settings (mode_sel, gamma_coe, RGB gains, Bayer start phase) into shadow registers over a valid/ready port.
- A commit request is applied atomically to the active outputs only at a frame boundary, so gains, gamma and mode never change mid-frame.
- Sits between the host/register bus and the pipeline top; tracks frame position from data_en and the active geometry.

Parameters:
- GEOM_W, 12, width of h_active_in / v_active_in and the pixel/line counters
- GAIN_RST, 8'h40, reset value of r/g/b gains (unity, Q2.6)
- MODE_RST, 3'b100, reset value of mode_sel (full process path)
- BAYER_RST, 4'b0001, reset value of bayer_start

Ports:
- isp_clk  in  1  pipeline clock
- rst_n  in  1  asynchronous reset, active-low
- data_en  in  1  pixel valid at pipeline input
- h_active_in  in  GEOM_W  pixels per line
- v_active_in  in  GEOM_W  lines per frame
- cfg_valid  in  1  host write request
- cfg_ready  out  1  controller accepts the write this cycle
- cfg_addr  in  3  register select
- cfg_wdata  in  8  write data
- mode_sel  out  3  active mode (one-hot)
- gamma_coe  out  3  active gamma select
- r_gain / g_gain / b_gain  out  8 each  active gains
- bayer_start  out  4  active Bayer start phase (one-hot)
- cfg_pending  out  1  commit armed, not yet applied
- frame_start  out  1  pulse on the first pixel of a frame
- frame_end  out  1  pulse on the last pixel of a frame
- frame_cnt  out  16  completed frames, wraps at 16'hFFFF -> 0

Behaviour:
- Reset (async, rst_n low):
  - Active and shadow registers take MODE_RST, 0, GAIN_RST x3, BAYER_RST.
  - cfg_pending = 0, cfg_ready = 1, frame_start = frame_end = 0, frame_cnt = 0.
  - Counters are cleared and the FSM goes to IDLE.
  - Reset mid-frame or with a commit pending discards both.
- Write handshake:
  - Transfer occurs when cfg_valid & cfg_ready.
  - Register map (cfg_addr):
    - 0: mode_sel = wdata[2:0]
    - 1: gamma_coe = wdata[2:0]
    - 2: r_gain
    - 3: g_gain
    - 4: b_gain
    - 5: bayer_start = wdata[3:0]
    - 6: commit (data ignored)
    - 7: reserved, accepted and ignored
  - cfg_ready = !cfg_pending. Shadow registers are locked while a commit is armed.
- FSM states: IDLE, ACTIVE.
  - IDLE: no frame in progress.
    - Armed commit applies on the next cycle: active values update at N+1 after commit acceptance at N, and cfg_pending is cleared at N+1.
    - data_en = 1 latches h_active_in / v_active_in into geometry registers, pulses frame_start in the same cycle, counts the pixel, and goes to ACTIVE.
  - ACTIVE:
    - Each data_en increments pix_cnt. At pix_cnt == h_geom-1, pix_cnt goes to 0 and line_cnt increments.
    - A data_en = 0 gap (line/frame blanking) holds all counters.
    - On the last pixel of the frame (pix_cnt == h_geom-1, line_cnt == v_geom-1, data_en = 1): frame_end pulses in that cycle, frame_cnt increments, and the FSM returns to IDLE.
    - If cfg_pending, active registers update on the following cycle.
- Geometry:
  - Changes to h_active_in / v_active_in during ACTIVE are ignored until the next frame start.
  - A geometry value of 0 is treated as 2^GEOM_W (the compare target wraps).
- Simultaneous events:
  - Commit accepted in the same cycle as frame_end: applied at this boundary (active updates next cycle).
  - Commit accepted in the same cycle as a frame_start pixel: deferred to the end of that frame.
  - Shadow write and commit cannot coincide (single address per transfer).
- Single-pixel frame (h_geom = v_geom = 1): frame_start and frame_end pulse in the same cycle, and the FSM stays in IDLE.
- All outputs are registered. Latency from frame_end to updated active values is 1 cycle.

Optional Feature:
- Macro ISP_CFG_READBACK_EN.
- When defined, adds three ports:
  - rd_addr (in 3)
  - rd_sel (in 1): selects shadow (1) or active (0)
  - rd_data (out 8): registered, 1-cycle latency, zero-extended.
  - Address 6 returns {7'b0, cfg_pending}. Address 7 returns frame_cnt[7:0].
- When undefined, these ports are absent and behaviour is otherwise identical.

Decomposition:
- Shared package isp_cfg_pkg holds:
  - register address constants (ADDR_MODE .. ADDR_COMMIT)
  - FSM state encoding
  - reset-default constants
- One natural sub-module, isp_frame_tracker: geometry latch, pix/line counters, frame_start/frame_end/frame_cnt.
- isp_cfg_ctrl holds the shadow/active registers and commit logic.

Test Plan:
- Reset, then idle: outputs are mode 3'b100, gains 8'h40, gamma 0, bayer 4'b0001, cfg_ready 1, frame_cnt 0.
- Geometry 4x2, continuous data_en for 8 cycles: frame_start on cycle 1, frame_end on cycle 8, frame_cnt = 1, FSM back in IDLE.
- Mid-frame (pixel 3 of 4x2), write r_gain = 8'h80 then commit:
  - r_gain stays 8'h40 and cfg_ready = 0 until frame_end.
  - r_gain = 8'h80 one cycle after frame_end, then cfg_pending = 0 and cfg_ready = 1.
- Commit accepted on the exact frame_end cycle: new values visible the next cycle. Commit on a frame_start cycle: new values visible only after that frame's frame_end.
- Change h_active_in 4 -> 6 mid-frame: current frame still ends after 8 pixels. Next frame with v = 2 ends after 12 pixels.
- Gaps of data_en = 0 inserted between pixels of a 4x2 frame: counters hold and frame_end still occurs on the 8th valid pixel. rst_n asserted mid-frame with a commit pending: all values return to defaults and cfg_pending = 0.
